// File: rtl/imem_loader_if.sv
// Byte-stream intake and IMEM write port of the boot loader.
// The slave modport is the loader; the master side feeds bytes and observes writes.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: assembles a counted, XOR-checksummed little-endian byte image into
// IMEM words and holds the core in reset until the whole image has been verified.
module imem_loader #(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 100000
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         core_rstn,
  output logic         busy,
  output logic         error
);

  localparam int                TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [16:0]       DEPTH_L  = 17'(DEPTH);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]   IDX_ONE  = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    HDR0 = 3'd0,
    HDR1 = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    RUN  = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t            state_r;
  logic              rx_ready_r;
  logic              imem_we_r;
  logic [ADDR_W-1:0] imem_addr_r;
  logic [31:0]       imem_wdata_r;
  logic              core_rstn_r;
  logic              busy_r;
  logic              error_r;
  logic [7:0]        cnt_lo_r;
  logic [ADDR_W:0]   n_r;
  logic [ADDR_W:0]   word_idx_r;
  logic [1:0]        lane_r;
  logic [23:0]       word_r;
  logic [7:0]        xor_r;
  logic [TMO_W-1:0]  tmo_r;

  logic              xfer_s;
  logic [15:0]       n_s;
  logic              n_ok_s;
  logic              tmo_hit_s;
  logic              last_word_s;

  // Handshake, header decode and end-of-phase flags
  always_comb begin
    xfer_s      = bus.rx_valid & rx_ready_r;
    n_s         = {bus.rx_data, cnt_lo_r};
    n_ok_s      = (n_s != 16'd0) && ({1'b0, n_s} <= DEPTH_L);
    tmo_hit_s   = (tmo_r == TMO_LAST);
    last_word_s = (word_idx_r == (n_r - IDX_ONE));
  end

  // Loader FSM with all outputs registered
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= HDR0;
      rx_ready_r   <= 1'b1;
      imem_we_r    <= 1'b0;
      imem_addr_r  <= '0;
      imem_wdata_r <= 32'd0;
      core_rstn_r  <= 1'b0;
      busy_r       <= 1'b0;
      error_r      <= 1'b0;
      cnt_lo_r     <= 8'd0;
      n_r          <= '0;
      word_idx_r   <= '0;
      lane_r       <= 2'd0;
      word_r       <= 24'd0;
      xor_r        <= 8'd0;
      tmo_r        <= '0;
    end else if (start) begin
      // A coincident byte is swallowed here; IMEM address/data are left as they were
      state_r      <= HDR0;
      rx_ready_r   <= 1'b1;
      imem_we_r    <= 1'b0;
      core_rstn_r  <= 1'b0;
      busy_r       <= 1'b0;
      error_r      <= 1'b0;
      cnt_lo_r     <= 8'd0;
      n_r          <= '0;
      word_idx_r   <= '0;
      lane_r       <= 2'd0;
      word_r       <= 24'd0;
      xor_r        <= 8'd0;
      tmo_r        <= '0;
    end else begin
      imem_we_r <= 1'b0;
      case (state_r)
        HDR0: begin
          if (xfer_s) begin
            cnt_lo_r <= bus.rx_data;
            busy_r   <= 1'b1;
            tmo_r    <= '0;
            state_r  <= HDR1;
          end
        end
        HDR1: begin
          if (xfer_s) begin
            tmo_r <= '0;
            if (n_ok_s) begin
              n_r        <= n_s[ADDR_W:0];
              word_idx_r <= '0;
              lane_r     <= 2'd0;
              xor_r      <= 8'd0;
              state_r    <= DATA;
            end else begin
              state_r     <= ERR;
              error_r     <= 1'b1;
              busy_r      <= 1'b0;
              core_rstn_r <= 1'b0;
            end
          end else if (tmo_hit_s) begin
            state_r     <= ERR;
            error_r     <= 1'b1;
            busy_r      <= 1'b0;
            core_rstn_r <= 1'b0;
          end else begin
            tmo_r <= tmo_r + TMO_W'(1);
          end
        end
        DATA: begin
          if (xfer_s) begin
            tmo_r  <= '0;
            xor_r  <= xor_r ^ bus.rx_data;
            lane_r <= lane_r + 2'd1;
            if (lane_r == 2'd3) begin
              imem_we_r    <= 1'b1;
              imem_addr_r  <= word_idx_r[ADDR_W-1:0];
              imem_wdata_r <= {bus.rx_data, word_r};
              word_idx_r   <= word_idx_r + IDX_ONE;
              if (last_word_s) begin
                state_r <= CSUM;
              end
            end else begin
              word_r[{lane_r, 3'b000} +: 8] <= bus.rx_data;
            end
          end else if (tmo_hit_s) begin
            state_r     <= ERR;
            error_r     <= 1'b1;
            busy_r      <= 1'b0;
            core_rstn_r <= 1'b0;
          end else begin
            tmo_r <= tmo_r + TMO_W'(1);
          end
        end
        CSUM: begin
          if (xfer_s) begin
            tmo_r <= '0;
            if (bus.rx_data == xor_r) begin
              state_r     <= RUN;
              core_rstn_r <= 1'b1;
              busy_r      <= 1'b0;
              rx_ready_r  <= 1'b0;
            end else begin
              state_r     <= ERR;
              error_r     <= 1'b1;
              busy_r      <= 1'b0;
              core_rstn_r <= 1'b0;
            end
          end else if (tmo_hit_s) begin
            state_r     <= ERR;
            error_r     <= 1'b1;
            busy_r      <= 1'b0;
            core_rstn_r <= 1'b0;
          end else begin
            tmo_r <= tmo_r + TMO_W'(1);
          end
        end
        RUN: begin
          core_rstn_r <= 1'b1;
          rx_ready_r  <= 1'b0;
        end
        ERR: begin
          // Keep draining the stream so the upstream never stalls
          rx_ready_r <= 1'b1;
        end
        default: begin
          state_r     <= ERR;
          error_r     <= 1'b1;
          busy_r      <= 1'b0;
          core_rstn_r <= 1'b0;
          rx_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.rx_ready   = rx_ready_r;
  assign bus.imem_we    = imem_we_r;
  assign bus.imem_addr  = imem_addr_r;
  assign bus.imem_wdata = imem_wdata_r;
  assign core_rstn      = core_rstn_r;
  assign busy           = busy_r;
  assign error          = error_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized image loads against a word-level reference of the
// image format (count, payload words, XOR checksum of all payload bytes).
module tb_imem_loader;

  logic CLK = 1'b0;
  logic RST;
  logic start;
  logic core_rstn;
  logic busy;
  logic error;

  int n_checks = 0;
  int n_fail   = 0;
  int total_we = 0;

  imem_loader_if #(.ADDR_W(10)) bus ();

  imem_loader #(.DEPTH(1024), .ADDR_W(10), .TIMEOUT(16)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .bus      (bus),
    .core_rstn(core_rstn),
    .busy     (busy),
    .error    (error)
  );

  always #5 CLK = ~CLK;

  // Count write strobes away from the active edge
  always @(negedge CLK) begin
    if (bus.imem_we === 1'b1) total_we++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int g);
    repeat (g) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference checksum: fold the XOR of all payload words down to one byte
  function automatic logic [7:0] model_csum(input logic [31:0] words[$]);
    logic [31:0] acc;
    acc = 32'd0;
    foreach (words[i]) acc ^= words[i];
    return acc[7:0] ^ acc[15:8] ^ acc[23:16] ^ acc[31:24];
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    check("rx_ready_wait", 32'(guard < 50), 32'd1);
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_core_rstn", core_rstn, 32'd0);
    check("start_error", error, 32'd0);
    check("start_busy", busy, 32'd0);
    check("start_rx_ready", bus.rx_ready, 32'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_rx_ready", bus.rx_ready, 32'd1);
    check("rst_imem_we", bus.imem_we, 32'd0);
    check("rst_imem_addr", bus.imem_addr, 32'd0);
    check("rst_imem_wdata", bus.imem_wdata, 32'd0);
    check("rst_core_rstn", core_rstn, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_error", error, 32'd0);
  endtask

  // Send one full image; expectations come from the word list and the model checksum
  task automatic run_image(input int n, input logic [31:0] words[$], input logic [7:0] csum,
                           input int gap);
    int base;
    bit good;
    good = (csum == model_csum(words));
    base = total_we;
    send_byte(8'(n));
    idle(gap);
    check("busy_after_lo", busy, 32'd1);
    send_byte(8'(n >> 8));
    idle(gap);
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 4; b++) begin
        send_byte(words[i][8*b +: 8]);
        if (b == 3) begin
          check("word_we", bus.imem_we, 32'd1);
          check("word_addr", bus.imem_addr, 32'(i));
          check("word_data", bus.imem_wdata, words[i]);
        end
        idle(gap);
      end
    end
    send_byte(csum);
    check("end_core_rstn", core_rstn, 32'(good));
    check("end_error", error, 32'(!good));
    check("end_busy", busy, 32'd0);
    check("end_rx_ready", bus.rx_ready, 32'(!good));
    check("we_count", 32'(total_we - base), 32'(n));
  endtask

  initial begin
    logic [31:0] w[$];
    int base;
    int n;
    RST          = 1'b1;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    idle(3);
    check_reset_outputs();
    RST = 1'b0;
    tick();

    // Single-word image from the worked example
    w = '{32'h00A00513};
    check("model_b6", 32'(model_csum(w)), 32'h0000_00B6);
    run_image(1, w, 8'hB6, 0);
    base = total_we;
    bus.rx_data  = 8'h55;
    bus.rx_valid = 1'b1;
    idle(5);
    bus.rx_valid = 1'b0;
    check("run_ignores_rx", 32'(total_we - base), 32'd0);
    check("run_core_rstn", core_rstn, 32'd1);
    do_start();

    // Three words with valid toggling every other cycle
    w = '{32'h11111111, 32'h22222222, 32'h33333333};
    run_image(3, w, 8'h00, 1);
    do_start();

    // Illegal counts
    send_byte(8'h00);
    send_byte(8'h00);
    check("n0_error", error, 32'd1);
    check("n0_core_rstn", core_rstn, 32'd0);
    check("n0_busy", busy, 32'd0);
    check("err_rx_ready", bus.rx_ready, 32'd1);
    do_start();
    send_byte(8'h01);
    send_byte(8'h04);
    check("n1025_error", error, 32'd1);
    check("n1025_core_rstn", core_rstn, 32'd0);
    do_start();

    // Bad checksum, then recovery
    w = '{32'h00A00513};
    run_image(1, w, 8'hB7, 0);
    do_start();
    run_image(1, w, 8'hB6, 0);
    do_start();

    // Timeout mid-image
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    idle(15);
    check("tmo_not_yet", error, 32'd1 - 32'd1);
    check("tmo_busy_held", busy, 32'd1);
    tick();
    check("tmo_error", error, 32'd1);
    check("tmo_busy", busy, 32'd0);
    do_start();
    idle(100);
    check("hdr0_idle_error", error, 32'd0);
    check("hdr0_idle_busy", busy, 32'd0);

    // start beats a byte handshake in HDR0
    bus.rx_data  = 8'h05;
    bus.rx_valid = 1'b1;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    check("start_hdr0_busy", busy, 32'd0);
    w = '{32'hDEADBEEF};
    run_image(1, w, model_csum(w), 0);

    // start during RUN with a concurrent byte
    bus.rx_data  = 8'h02;
    bus.rx_valid = 1'b1;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    check("run_start_core_rstn", core_rstn, 32'd0);
    check("run_start_busy", busy, 32'd0);
    w = '{$urandom(), $urandom()};
    run_image(2, w, model_csum(w), 0);
    do_start();

    // RST in the middle of DATA
    send_byte(8'h03);
    send_byte(8'h00);
    for (int i = 0; i < 9; i++) send_byte(8'($urandom_range(1, 255)));
    check("mid_addr_1", bus.imem_addr, 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_reset_outputs();

    // Randomized images, some with corrupted checksums
    for (int k = 0; k < 6; k++) begin
      logic [7:0] cs;
      n = $urandom_range(1, 8);
      w = {};
      for (int i = 0; i < n; i++) w.push_back($urandom());
      cs = model_csum(w);
      if ($urandom_range(0, 1) == 1) cs = cs ^ 8'($urandom_range(1, 255));
      run_image(n, w, cs, $urandom_range(0, 2));
      do_start();
    end

    // Full-depth image
    w = {};
    for (int i = 0; i < 1024; i++) w.push_back($urandom());
    run_image(1024, w, model_csum(w), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader that sits directly upstream of the core's instruction memory.
- Takes a byte stream from the UART receiver (valid/ready) and assembles little-endian 32-bit words.
- Writes the words into the 1024-word IMEM at the same 10-bit word addresses the core fetches from.
- Holds the core in reset until a complete, checksum-verified image is loaded, then releases it.

Parameters:
- DEPTH, 1024, IMEM depth in 32-bit words; legal word counts are 1..DEPTH.
- ADDR_W, 10, IMEM word-address width; matches the core's instruction address port.
- TIMEOUT, 100000, maximum consecutive cycles without an accepted byte while mid-image before aborting.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse: abort everything and wait for a new image.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts the byte this cycle; transfer = rx_valid & rx_ready.
- imem_we  out  1  IMEM write strobe, one cycle per word.
- imem_addr  out  ADDR_W  IMEM word address.
- imem_wdata  out  32  IMEM write data.
- core_rstn  out  1  active-low reset to the core; 1 = core running.
- busy  out  1  image load in progress.
- error  out  1  last load aborted; sticky until start or RST.

Behaviour:
- Image format: CNT_LO, CNT_HI, then 4*N payload bytes (little-endian, word 0 first), then one CSUM byte.
- N = {CNT_HI, CNT_LO}. CSUM = XOR of all payload bytes; header bytes are excluded.
- States: HDR0, HDR1, DATA, CSUM, RUN, ERR. All outputs are registered.
- Reset values: state = HDR0, rx_ready = 1, imem_we = 0, imem_addr = 0, imem_wdata = 0, core_rstn = 0, busy = 0, error = 0, counters = 0, xor accumulator = 0.
- RST mid-load returns to the reset state; IMEM contents are not cleared.
- rx_ready = 1 in HDR0, HDR1, DATA, CSUM and ERR; 0 in RUN.
- In ERR, bytes are accepted and discarded so the upstream never stalls.
- HDR0: the first byte latches CNT_LO, busy goes to 1, and the state moves to HDR1. No timeout applies while waiting in HDR0.
- HDR1: the byte forms N.
  - N == 0 or N > DEPTH -> ERR.
  - Otherwise -> DATA, with word index = 0, byte lane = 0 and xor = 0.
- DATA, per byte:
  - The byte goes into lane (lane 0 = bits 7:0).
  - xor ^= byte; lane increments mod 4.
  - On the lane-3 byte: the cycle after the handshake, imem_we = 1, imem_addr = word index and imem_wdata = the assembled word, for exactly one cycle. Word index then increments.
  - After word N-1 is written -> CSUM.
- CSUM: the byte is compared with xor.
  - Match -> RUN: next cycle core_rstn = 1, busy = 0.
  - Mismatch -> ERR.
- RUN: core_rstn = 1, and the loader ignores rx. It stays in RUN until start or RST.
- ERR: error = 1, busy = 0, core_rstn = 0.
- Timeout: a cycle counter clears on every accepted byte and on entry to HDR1.
  - In HDR1, DATA or CSUM, when TIMEOUT consecutive cycles pass with no accepted byte -> ERR.
- start (any state) takes priority over a byte handshake in the same cycle; that byte is consumed and discarded.
  - Next cycle: state = HDR0, core_rstn = 0, error = 0, busy = 0, counters and xor cleared, imem_we = 0.
- Partially written IMEM after an abort is left as-is; the core stays in reset, so it is never executed.
- Word index width is ADDR_W + 1, so that N = DEPTH = 1024 does not wrap.

Test Plan:
- Bytes 01 00 13 05 A0 00 then CSUM = 13^05^A0^00 = B6 -> one imem_we pulse at addr 0 with data 0x00A00513 one cycle after the 4th payload byte; core_rstn rises the cycle after the CSUM byte; busy returns to 0.
- N = 3 with words 0x11111111, 0x22222222, 0x33333333 and CSUM 0x00, with rx_valid toggling every other cycle -> writes at addrs 0, 1, 2 in order, one pulse each; core_rstn = 1 at the end.
- Header 00 00 -> ERR, error = 1, core_rstn stays 0. Header 01 04 (N = 1025) -> ERR.
- Valid N = 1 image with a wrong CSUM (B7) -> the word is written, then error = 1 and core_rstn stays 0. A start pulse clears error, and a correct image afterwards releases the core.
- TIMEOUT = 16: send CNT_LO, CNT_HI = 2, 3 payload bytes, then idle -> ERR exactly 16 idle cycles after the last accepted byte. Idling in HDR0 for 100 cycles causes no error.
- In RUN, start coincident with rx_valid -> core_rstn drops next cycle; the concurrent byte is discarded (not taken as CNT_LO), and the next byte is taken as CNT_LO. RST asserted during DATA -> all outputs at reset values the next cycle.
